// File: rtl/ntm_scalar_adder_arbiter_if.sv
// Request/response bundle between the gate-vector engines, the shared adder and its consumer.
// master = requesters + consumer side, slave = arbiter side.
interface ntm_scalar_adder_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_SIZE = 8,
    localparam int ID_W     = $clog2(N_REQ)
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*DATA_SIZE-1:0] req_in1;
    logic [N_REQ*DATA_SIZE-1:0] req_in2;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [DATA_SIZE:0]         rsp_data;

    modport master (
        output req_valid, req_in1, req_in2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_in1, req_in2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/ntm_scalar_adder_arbiter.sv
// Round-robin shared 8-bit adder for the LSTM controller gate engines.
// One registered, tagged DATA_SIZE+1 bit sum per accepted request, 1-cycle latency.
module ntm_scalar_adder_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_SIZE = 8
) (
    input logic                     clk,
    input logic                     rst,
    ntm_scalar_adder_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0][DATA_SIZE-1:0] in1, in2;
    logic [ID_W-1:0]                 ptr, gnt;
    logic                            any_vld, can_issue, issue;
    logic [N_REQ-1:0]                ready;
    logic                            rsp_valid;
    logic [ID_W-1:0]                 rsp_id;
    logic [DATA_SIZE:0]              rsp_data;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign in1[i] = bus.req_in1[i*DATA_SIZE +: DATA_SIZE];
        assign in2[i] = bus.req_in2[i*DATA_SIZE +: DATA_SIZE];
    end

    // Scan ptr, ptr+1, ... with wrap; the first valid requester wins.
    always_comb begin
        int j;
        j       = 0;
        any_vld = 1'b0;
        gnt     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any_vld && bus.req_valid[j]) begin
                any_vld = 1'b1;
                gnt     = ID_W'(j);
            end
        end
    end

    assign can_issue = !rsp_valid || bus.rsp_ready;
    assign issue     = can_issue && any_vld;

    // Gated by rst so no requester sees an accept while the block is held in reset.
    always_comb begin
        ready = '0;
        if (rst && issue) ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            ptr       <= '0;
        end else if (issue) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt;
            rsp_data  <= {1'b0, in1[gnt]} + {1'b0, in2[gnt]};
            ptr       <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
endmodule
